// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: single-outstanding data bus access, store lane encoding, load formatting.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rd,
   input  logic        regwe,
   input  logic [31:0] result,
   input  logic [2:0]  loadctl,
   input  logic [2:0]  storectl,
   input  logic [31:0] storedata,
   input  logic [5:0]  stall,
   output logic [4:0]  rd_o,
   output logic        regwe_o,
   output logic [31:0] wdata_o,
   output logic        stallreq_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        misalign_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d, cur_state;
   logic [31:0] addr_q, addr_d, mwdata_q, mwdata_d, rdata_q, rdata_d;
   logic [3:0]  be_q, be_d;
   logic        we_q, we_d;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  ld_q, ld_d;
   logic [1:0]  off_q, off_d;

   logic        is_ld, is_st, mem_op, misal;
   logic [1:0]  size;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        unused_stall;

   assign unused_stall = ^{stall[5], stall[3:0]};

   // Loads win over stores; size code is shared by both encodings (01 byte, 10 half, 11 word).
   assign is_ld  = |loadctl;
   assign is_st  = ~is_ld & (|storectl);
   assign mem_op = is_ld | is_st;
   assign size   = is_ld ? loadctl[1:0] : storectl[1:0];
   assign misal  = mem_op & (((size == 2'b10) & result[0]) | ((size == 2'b11) & (|result[1:0])));

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = storedata;
      case (storectl[1:0])
         2'b01: begin
            st_be    = 4'b0001 << result[1:0];
            st_wdata = {4{storedata[7:0]}};
         end
         2'b10: begin
            st_be    = 4'b0011 << result[1:0];
            st_wdata = {2{storedata[15:0]}};
         end
         default: ;
      endcase
   end

   assign byte_sel = rdata_q[{off_q, 3'b000} +: 8];
   assign half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

   always_comb begin
      case (ld_q[1:0])
         2'b01:   ld_data = {{24{~ld_q[2] & byte_sel[7]}}, byte_sel};
         2'b10:   ld_data = {{16{~ld_q[2] & half_sel[15]}}, half_sel};
         default: ld_data = rdata_q;
      endcase
   end

   // Combinational outputs behave as IDLE while reset is held.
   assign cur_state = rst ? IDLE : state_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      mwdata_d   = mwdata_q;
      rdata_d    = rdata_q;
      be_d       = be_q;
      we_d       = we_q;
      rd_d       = rd_q;
      ld_d       = ld_q;
      off_d      = off_q;
      rd_o       = rd;
      regwe_o    = regwe;
      wdata_o    = result;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
      case (cur_state)
         IDLE: begin
            if (misal) begin
               misalign_o = 1'b1;
               regwe_o    = 1'b0;
            end else if (mem_op) begin
               stallreq_o = 1'b1;
               regwe_o    = 1'b0;
               state_d    = REQ;
               addr_d     = {result[31:2], 2'b00};
               we_d       = is_st;
               be_d       = is_st ? st_be : 4'b1111;
               mwdata_d   = is_st ? st_wdata : 32'd0;
               rd_d       = rd;
               ld_d       = is_ld ? loadctl : 3'b000;
               off_d      = result[1:0];
            end
         end
         REQ: begin
            rd_o       = rd_q;
            regwe_o    = 1'b0;
            wdata_o    = 32'd0;
            stallreq_o = 1'b1;
            if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            rd_o    = rd_q;
            regwe_o = |ld_q;
            wdata_o = (|ld_q) ? ld_data : 32'd0;
            if (!stall[4]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= 32'd0;
         mwdata_q <= 32'd0;
         rdata_q  <= 32'd0;
         be_q     <= 4'd0;
         we_q     <= 1'b0;
         rd_q     <= 5'd0;
         ld_q     <= 3'd0;
         off_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         mwdata_q <= mwdata_d;
         rdata_q  <= rdata_d;
         be_q     <= be_d;
         we_q     <= we_d;
         rd_q     <= rd_d;
         ld_q     <= ld_d;
         off_q    <= off_d;
      end
   end

   assign mem_req_o   = (state_q == REQ);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = mwdata_q;
endmodule
